parity_frame_receiver: RTL and testbench

Serial frame receiver that sits directly downstream of the serial parity FSM stage. It consumes the same one-bit-per-clock stream (`x`) and assembles `DATA_BITS` data bits, LSB first, followed by one parity bit. It then presents the recovered word together with a parity-error flag. It converts the bit-level parity stream into word-level, checked data for the next consumer.

---
 rtl/parity_rx_pkg.sv | 21 ++
 rtl/rx_word_reg.sv | 51 +++++
 rtl/parity_frame_receiver.sv | 121 ++++++++++++
 tb/tb_parity_frame_receiver.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/parity_rx_pkg.sv
// Shared types and constants for the parity frame receiver.
// Holds the FSM state encoding and the parity-sense constants.
package parity_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity check result: 1 when the accumulated data parity, the received
  // parity bit and the selected sense disagree.
  function automatic logic parity_check(input logic run_par, input logic par_bit,
                                        input logic sense);
    return run_par ^ par_bit ^ sense;
  endfunction

endpackage

// File: rtl/rx_word_reg.sv
// Indexed-write word register for the frame receiver.
// A load writes bit 0 and clears the rest; a plain write sets one bit by index.
module rx_word_reg
  import parity_rx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int IDX_W     = $clog2(DATA_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic                 i_wr_en,
  input  logic [IDX_W-1:0]     i_wr_idx,
  input  logic                 i_wr_bit,
  output logic [DATA_BITS-1:0] o_word
);

  logic [DATA_BITS-1:0] r_word;
  logic [DATA_BITS-1:0] w_word_nxt;

  // Next-word computation: load starts a fresh word, write touches one bit.
  always_comb begin
    w_word_nxt = r_word;
    if (i_load) begin
      w_word_nxt    = {DATA_BITS{1'b0}};
      w_word_nxt[0] = i_wr_bit;
    end else if (i_wr_en) begin
      for (int i = 0; i < DATA_BITS; i++) begin
        if (i_wr_idx == IDX_W'(i)) begin
          w_word_nxt[i] = i_wr_bit;
        end else begin
          w_word_nxt[i] = r_word[i];
        end
      end
    end else begin
      w_word_nxt = r_word;
    end
  end

  // Word storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word <= {DATA_BITS{1'b0}};
    end else begin
      r_word <= w_word_nxt;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/parity_frame_receiver.sv
// Serial frame receiver: assembles DATA_BITS data bits (LSB first) plus one
// parity bit into a checked word, with resync-abort on a mid-frame sync.
module parity_frame_receiver
  import parity_rx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int ODD       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 x,
  input  logic                 x_valid,
  input  logic                 sync,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 out_valid,
  output logic                 parity_err,
  output logic                 frame_abort,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  rx_state_t            r_state;
  logic [IDX_W-1:0]     r_count;
  logic                 r_run_par;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_out_valid;
  logic                 r_parity_err;
  logic                 r_frame_abort;
  logic                 r_busy;

  logic                 w_sense;
  logic                 w_load;
  logic                 w_wr_en;
  logic [DATA_BITS-1:0] w_word;

  assign w_sense = (ODD != 0) ? PAR_ODD : PAR_EVEN;
  assign w_load  = x_valid & sync;
  assign w_wr_en = x_valid & ~sync & (r_state == DATA);

  rx_word_reg #(
    .DATA_BITS (DATA_BITS),
    .IDX_W     (IDX_W)
  ) u_word (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_wr_en  (w_wr_en),
    .i_wr_idx (r_count),
    .i_wr_bit (x),
    .o_word   (w_word)
  );

  // Frame FSM, bit counter, running parity and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_count       <= {IDX_W{1'b0}};
      r_run_par     <= 1'b0;
      r_data_out    <= {DATA_BITS{1'b0}};
      r_out_valid   <= 1'b0;
      r_parity_err  <= 1'b0;
      r_frame_abort <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_out_valid   <= 1'b0;
      r_frame_abort <= 1'b0;
      if (x_valid && sync) begin
        // A sync always restarts the frame; it aborts one only if one is open.
        r_frame_abort <= (r_state != IDLE);
        r_run_par     <= x;
        r_busy        <= 1'b1;
        if (DATA_BITS == 1) begin
          r_state <= PARITY;
          r_count <= {IDX_W{1'b0}};
        end else begin
          r_state <= DATA;
          r_count <= IDX_W'(1);
        end
      end else if (x_valid) begin
        case (r_state)
          IDLE: begin
            r_state <= IDLE;
          end
          DATA: begin
            r_run_par <= r_run_par ^ x;
            r_count   <= r_count + IDX_W'(1);
            if (r_count == LAST_IDX) begin
              r_state <= PARITY;
            end else begin
              r_state <= DATA;
            end
          end
          PARITY: begin
            r_parity_err <= parity_check(r_run_par, x, w_sense);
            r_data_out   <= w_word;
            r_out_valid  <= 1'b1;
            r_busy       <= 1'b0;
            r_count      <= {IDX_W{1'b0}};
            r_state      <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_count <= {IDX_W{1'b0}};
          end
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign data_out    = r_data_out;
  assign out_valid   = r_out_valid;
  assign parity_err  = r_parity_err;
  assign frame_abort = r_frame_abort;
  assign busy        = r_busy;

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Directed self-checking bench for parity_frame_receiver (even and odd sense).
module tb_parity_frame_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       x;
  logic       x_valid;
  logic       sync;
  logic [7:0] data_out, data_out_o;
  logic       out_valid, out_valid_o;
  logic       parity_err, parity_err_o;
  logic       frame_abort, frame_abort_o;
  logic       busy, busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int ov_cnt   = 0;
  int ab_cnt   = 0;

  always #5 clk = ~clk;

  parity_frame_receiver #(.DATA_BITS(8), .ODD(0)) u_dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .sync(sync),
    .data_out(data_out), .out_valid(out_valid), .parity_err(parity_err),
    .frame_abort(frame_abort), .busy(busy)
  );

  parity_frame_receiver #(.DATA_BITS(8), .ODD(1)) u_dut_odd (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .sync(sync),
    .data_out(data_out_o), .out_valid(out_valid_o), .parity_err(parity_err_o),
    .frame_abort(frame_abort_o), .busy(busy_o)
  );

  // Pulse counters for the even-sense DUT.
  always @(negedge clk) begin
    if (out_valid === 1'b1) ov_cnt++;
    if (frame_abort === 1'b1) ab_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic b);
    @(negedge clk);
    x_valid = v;
    sync    = s;
    x       = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; x_valid = 1'b0; sync = 1'b0; x = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Sync + bits 1..7 of word, leaving the parity bit to the caller.
  task automatic send_data(input logic [7:0] w);
    drive(1'b1, 1'b1, w[0]);
    for (int i = 1; i < 8; i++) drive(1'b1, 1'b0, w[i]);
  endtask

  initial begin
    reset = 1'b1; x = 1'b0; x_valid = 1'b0; sync = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    check_eq("rst_data",  {24'd0, data_out}, 32'h0);
    check_eq("rst_ov",    {31'd0, out_valid}, 32'h0);
    check_eq("rst_perr",  {31'd0, parity_err}, 32'h0);
    check_eq("rst_abort", {31'd0, frame_abort}, 32'h0);
    check_eq("rst_busy",  {31'd0, busy}, 32'h0);

    // Scenario 1: 0xA5, parity 0.
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    check_eq("s1_busy_rise", {31'd0, busy}, 32'h1);
    for (int i = 2; i < 8; i++) drive(1'b1, 1'b0, 1'(8'hA5 >> i));
    drive(1'b1, 1'b0, 1'b0);
    check_eq("s1_busy_par", {31'd0, busy}, 32'h1);
    check_eq("s1_ov_early", {31'd0, out_valid}, 32'h0);
    drive(1'b0, 1'b0, 1'b0);
    check_eq("s1_ov",   {31'd0, out_valid}, 32'h1);
    check_eq("s1_data", {24'd0, data_out}, 32'hA5);
    check_eq("s1_perr", {31'd0, parity_err}, 32'h0);
    check_eq("s1_busy_fall", {31'd0, busy}, 32'h0);
    drive(1'b0, 1'b0, 1'b0);
    check_eq("s1_ov_pulse", {31'd0, out_valid}, 32'h0);

    // Scenario 2: 0xA5, parity 1.
    send_data(8'hA5);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check_eq("s2_ov",   {31'd0, out_valid}, 32'h1);
    check_eq("s2_data", {24'd0, data_out}, 32'hA5);
    check_eq("s2_perr", {31'd0, parity_err}, 32'h1);

    // Scenario 3: stalls between bits 3 and 4 and before parity.
    drive(1'b0, 1'b0, 1'b0);
    ov_cnt = 0;
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 4; i++) drive(1'b1, 1'b0, 1'(8'hA5 >> i));
    repeat (3) drive(1'b0, 1'b0, 1'b1);
    for (int i = 4; i < 8; i++) drive(1'b1, 1'b0, 1'(8'hA5 >> i));
    repeat (2) drive(1'b0, 1'b0, 1'b1);
    check_eq("s3_busy_stall", {31'd0, busy}, 32'h1);
    check_eq("s3_ov_stall", {31'd0, out_valid}, 32'h0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check_eq("s3_ov",   {31'd0, out_valid}, 32'h1);
    check_eq("s3_data", {24'd0, data_out}, 32'hA5);
    check_eq("s3_perr", {31'd0, parity_err}, 32'h0);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    check_eq("s3_ov_count", ov_cnt, 32'd1);

    // Scenario 4: five bits, then resync with 0x3C.
    do_reset();
    ov_cnt = 0; ab_cnt = 0;
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 5; i++) drive(1'b1, 1'b0, 1'(i & 1));
    send_data(8'h3C);
    check_eq("s4_abort", {31'd0, frame_abort}, 32'h0);
    drive(1'b1, 1'b0, 1'b0);
    check_eq("s4_data_hold", {24'd0, data_out}, 32'h00);
    drive(1'b0, 1'b0, 1'b0);
    check_eq("s4_ov",   {31'd0, out_valid}, 32'h1);
    check_eq("s4_data", {24'd0, data_out}, 32'h3C);
    check_eq("s4_perr", {31'd0, parity_err}, 32'h0);
    drive(1'b0, 1'b0, 1'b0);
    check_eq("s4_abort_count", ab_cnt, 32'd1);
    check_eq("s4_ov_count", ov_cnt, 32'd1);

    // Scenario 5: odd sense, 0xFF parity 1 then back-to-back 0xFF parity 0.
    send_data(8'hFF);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    check_eq("s5a_ov",   {31'd0, out_valid_o}, 32'h1);
    check_eq("s5a_data", {24'd0, data_out_o}, 32'hFF);
    check_eq("s5a_perr", {31'd0, parity_err_o}, 32'h0);
    check_eq("s5a_even_perr", {31'd0, parity_err}, 32'h1);
    check_eq("s5a_abort", {31'd0, frame_abort_o}, 32'h0);
    for (int i = 1; i < 8; i++) drive(1'b1, 1'b0, 1'b1);
    check_eq("s5b_busy", {31'd0, busy_o}, 32'h1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check_eq("s5b_ov",   {31'd0, out_valid_o}, 32'h1);
    check_eq("s5b_perr", {31'd0, parity_err_o}, 32'h1);
    check_eq("s5b_even_perr", {31'd0, parity_err}, 32'h0);

    // Scenario 6: reset mid-frame, then unsynced bits.
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 5; i++) drive(1'b1, 1'b0, 1'b1);
    ov_cnt = 0; ab_cnt = 0;
    do_reset();
    check_eq("s6_data", {24'd0, data_out}, 32'h0);
    check_eq("s6_busy", {31'd0, busy}, 32'h0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check_eq("s6_busy_after", {31'd0, busy}, 32'h0);
    check_eq("s6_perr", {31'd0, parity_err}, 32'h0);
    check_eq("s6_data_o", {24'd0, data_out_o}, 32'h0);
    check_eq("s6_ov_count", ov_cnt, 32'd0);
    check_eq("s6_abort_count", ab_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
